// File: rtl/physics_pkg.sv
// Shared types and constants for the collision scheduler slice.
//   sched_state_t     : scheduler FSM states
//   pos_t/vel_t/acc_t : default-width signed physics quantities
//   MIN_POLY_VERTICES : smallest vertex count that forms a polygon
package physics_pkg;

  localparam int unsigned POS_W = 8;
  localparam int unsigned VEL_W = 8;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned MIN_POLY_VERTICES = 3;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_CHAIN,
    S_NEXT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/sat_accumulator.sv
// Widened acceleration accumulator for one axis.
//   i_acc : running sum at SUM_W bits
//   i_add : new acceleration sample (IN_W bits, sign-extended)
//   o_sum : i_acc + i_add at SUM_W bits
//   o_sat : i_acc saturated to IN_W bits
module sat_accumulator #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned SUM_W = 10
) (
  input  logic signed [SUM_W-1:0] i_acc,
  input  logic signed [IN_W-1:0]  i_add,
  output logic signed [SUM_W-1:0] o_sum,
  output logic signed [IN_W-1:0]  o_sat
);

  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((64'sd1 <<< (IN_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MINV = ~MAXV;

  logic signed [SUM_W-1:0] w_ext;

  always_comb begin
    w_ext = SUM_W'(i_add);
    o_sum = i_acc + w_ext;
    if (i_acc > MAXV) begin
      o_sat = IN_W'(MAXV);
    end else if (i_acc < MINV) begin
      o_sat = IN_W'(MINV);
    end else begin
      o_sat = IN_W'(i_acc);
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Runs one collision unit over every obstacle of a scene for one physics step.
// Fetches each obstacle from ROM, launches the unit, chains the resulting
// position/velocity/displacement into the next obstacle, accumulates
// accelerations and reports one final state per step.
//   clk_in/rst_n_in     : clock, async active-low reset
//   begin_in, *_in      : step start and initial kinematic state
//   obstacle_addr_out, rom_* : obstacle ROM interface
//   coll_*              : collision unit launch/result interface
//   busy_out/done_out   : status; x/y/vel/acc/collision_count/timeout_out results
module collision_scheduler
  import physics_pkg::*;
#(
  parameter int unsigned POSITION_SIZE     = POS_W,
  parameter int unsigned VELOCITY_SIZE     = VEL_W,
  parameter int unsigned ACCELERATION_SIZE = ACC_W,
  parameter int unsigned NUM_VERTICES      = 5,
  parameter int unsigned NUM_OBSTACLES     = 4,
  parameter int unsigned ROM_LATENCY       = 2,
  parameter int unsigned TIMEOUT_CYCLES    = 255,
  localparam int unsigned AW  = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1,
  localparam int unsigned NVW = $clog2(NUM_VERTICES) + 1,
  localparam int unsigned CW  = $clog2(NUM_OBSTACLES) + 1
) (
  input  logic                                             clk_in,
  input  logic                                             rst_n_in,
  input  logic                                             begin_in,
  input  logic signed [POSITION_SIZE-1:0]                  pos_x_in,
  input  logic signed [POSITION_SIZE-1:0]                  pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0]                  vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0]                  vel_y_in,
  input  logic signed [POSITION_SIZE-1:0]                  dx_in,
  input  logic signed [POSITION_SIZE-1:0]                  dy_in,
  output logic [AW-1:0]                                    obstacle_addr_out,
  input  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]  rom_obstacle_in,
  input  logic [NVW-1:0]                                   rom_num_vertices_in,
  output logic                                             coll_begin_out,
  output logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]  coll_obstacle_out,
  output logic [NVW-1:0]                                   coll_num_vertices_out,
  output logic signed [POSITION_SIZE-1:0]                  coll_pos_x_out,
  output logic signed [POSITION_SIZE-1:0]                  coll_pos_y_out,
  output logic signed [POSITION_SIZE-1:0]                  coll_dx_out,
  output logic signed [POSITION_SIZE-1:0]                  coll_dy_out,
  output logic signed [VELOCITY_SIZE-1:0]                  coll_vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0]                  coll_vel_y_out,
  input  logic                                             coll_result_in,
  input  logic                                             coll_was_collision_in,
  input  logic signed [POSITION_SIZE-1:0]                  coll_x_new_in,
  input  logic signed [POSITION_SIZE-1:0]                  coll_y_new_in,
  input  logic signed [POSITION_SIZE-1:0]                  coll_x_int_in,
  input  logic signed [POSITION_SIZE-1:0]                  coll_y_int_in,
  input  logic signed [VELOCITY_SIZE-1:0]                  coll_vel_x_new_in,
  input  logic signed [VELOCITY_SIZE-1:0]                  coll_vel_y_new_in,
  input  logic signed [ACCELERATION_SIZE-1:0]              coll_acc_x_in,
  input  logic signed [ACCELERATION_SIZE-1:0]              coll_acc_y_in,
  output logic                                             busy_out,
  output logic                                             done_out,
  output logic signed [POSITION_SIZE-1:0]                  x_out,
  output logic signed [POSITION_SIZE-1:0]                  y_out,
  output logic signed [VELOCITY_SIZE-1:0]                  vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0]                  vel_y_out,
  output logic signed [ACCELERATION_SIZE-1:0]              acc_x_out,
  output logic signed [ACCELERATION_SIZE-1:0]              acc_y_out,
  output logic [CW-1:0]                                    collision_count_out,
  output logic                                             timeout_out
);

  localparam int unsigned SW  = ACCELERATION_SIZE + $clog2(NUM_OBSTACLES);
  localparam int unsigned RCW = $clog2(ROM_LATENCY + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t r_state, w_next;

  logic [AW-1:0]  r_idx;
  logic [RCW-1:0] r_rcnt;
  logic [TW-1:0]  r_tcnt;
  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0] r_obs;
  logic [NVW-1:0] r_nv;
  logic signed [POSITION_SIZE-1:0] r_pos_x, r_pos_y, r_dx, r_dy, r_x, r_y;
  logic signed [VELOCITY_SIZE-1:0] r_vel_x, r_vel_y, r_vx, r_vy;
  logic signed [SW-1:0] r_acc_x, r_acc_y, w_sum_x, w_sum_y;
  logic signed [ACCELERATION_SIZE-1:0] r_ax, r_ay, w_sat_x, w_sat_y;
  logic [CW-1:0] r_hits;
  logic r_timeout;
  logic w_rom_ready, w_tmo, w_last;

  assign w_rom_ready = (r_rcnt == RCW'(ROM_LATENCY - 1));
  assign w_tmo       = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_last      = (r_idx == AW'(NUM_OBSTACLES - 1));

  sat_accumulator #(.IN_W(ACCELERATION_SIZE), .SUM_W(SW)) u_acc_x (
    .i_acc(r_acc_x), .i_add(coll_acc_x_in), .o_sum(w_sum_x), .o_sat(w_sat_x)
  );

  sat_accumulator #(.IN_W(ACCELERATION_SIZE), .SUM_W(SW)) u_acc_y (
    .i_acc(r_acc_y), .i_add(coll_acc_y_in), .o_sum(w_sum_y), .o_sat(w_sat_y)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    busy_out       = (r_state != S_IDLE);
    coll_begin_out = 1'b0;
    done_out       = 1'b0;
    case (r_state)
      S_IDLE:   if (begin_in) w_next = S_FETCH;
      S_FETCH:  if (w_rom_ready) begin
                  w_next = (rom_num_vertices_in < NVW'(MIN_POLY_VERTICES)) ? S_NEXT : S_LAUNCH;
                end
      S_LAUNCH: begin
                  coll_begin_out = 1'b1;
                  w_next         = S_WAIT;
                end
      S_WAIT:   if (coll_result_in) w_next = S_CHAIN;
                else if (w_tmo)     w_next = S_NEXT;
      S_CHAIN:  w_next = S_NEXT;
      S_NEXT:   w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:   begin
                  done_out = 1'b1;
                  w_next   = S_IDLE;
                end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_idx <= '0;  r_rcnt <= '0;  r_tcnt <= '0;
      r_obs <= '0;  r_nv <= '0;
      r_pos_x <= '0; r_pos_y <= '0; r_dx <= '0; r_dy <= '0;
      r_vel_x <= '0; r_vel_y <= '0;
      r_acc_x <= '0; r_acc_y <= '0; r_hits <= '0; r_timeout <= 1'b0;
      r_x <= '0; r_y <= '0; r_vx <= '0; r_vy <= '0; r_ax <= '0; r_ay <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (begin_in) begin
          r_pos_x <= pos_x_in; r_pos_y <= pos_y_in;
          r_vel_x <= vel_x_in; r_vel_y <= vel_y_in;
          r_dx <= dx_in; r_dy <= dy_in;
          r_acc_x <= '0; r_acc_y <= '0; r_hits <= '0; r_timeout <= 1'b0;
          r_idx <= '0; r_rcnt <= '0;
        end
        S_FETCH: begin
          r_rcnt <= r_rcnt + RCW'(1);
          if (w_rom_ready) begin
            r_obs  <= rom_obstacle_in;
            r_nv   <= rom_num_vertices_in;
            r_rcnt <= '0;
          end
        end
        S_LAUNCH: r_tcnt <= '0;
        S_WAIT: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (!coll_result_in && w_tmo) r_timeout <= 1'b1;
        end
        S_CHAIN: if (coll_was_collision_in) begin
          r_pos_x <= coll_x_int_in;     r_pos_y <= coll_y_int_in;
          r_vel_x <= coll_vel_x_new_in; r_vel_y <= coll_vel_y_new_in;
          r_dx <= coll_x_new_in - coll_x_int_in;
          r_dy <= coll_y_new_in - coll_y_int_in;
          r_acc_x <= w_sum_x; r_acc_y <= w_sum_y;
          r_hits <= r_hits + CW'(1);
        end
        // Final results are registered on the way into DONE so they are
        // already valid in the same cycle that done_out pulses.
        S_NEXT: if (!w_last) begin
          r_idx  <= r_idx + AW'(1);
          r_rcnt <= '0;
        end else begin
          r_x  <= r_pos_x + r_dx;  r_y  <= r_pos_y + r_dy;
          r_vx <= r_vel_x;         r_vy <= r_vel_y;
          r_ax <= w_sat_x;         r_ay <= w_sat_y;
        end
        default: ;
      endcase
    end
  end

  assign obstacle_addr_out     = r_idx;
  assign coll_obstacle_out     = r_obs;
  assign coll_num_vertices_out = r_nv;
  assign coll_pos_x_out        = r_pos_x;
  assign coll_pos_y_out        = r_pos_y;
  assign coll_dx_out           = r_dx;
  assign coll_dy_out           = r_dy;
  assign coll_vel_x_out        = r_vel_x;
  assign coll_vel_y_out        = r_vel_y;
  assign x_out                 = r_x;
  assign y_out                 = r_y;
  assign vel_x_out             = r_vx;
  assign vel_y_out             = r_vy;
  assign acc_x_out             = r_ax;
  assign acc_y_out             = r_ay;
  assign collision_count_out   = r_hits;
  assign timeout_out           = r_timeout;

endmodule

// File: tb/tb_collision_scheduler.sv
module tb_collision_scheduler;
  import physics_pkg::*;

  localparam int NOBS = 2, NV = 5, ROM_LAT = 2, TMO = 255;

  logic clk = 1'b0, rst_n = 1'b0, begin_in = 1'b0;
  pos_t pos_x_in = '0, pos_y_in = '0, dx_in = '0, dy_in = '0;
  vel_t vel_x_in = '0, vel_y_in = '0;
  logic [0:0] obstacle_addr_out;
  logic [1:0][NV-1:0][7:0] rom_obstacle_in, coll_obstacle_out;
  logic [3:0] rom_num_vertices_in, coll_num_vertices_out;
  logic coll_begin_out, busy_out, done_out, timeout_out;
  pos_t coll_pos_x_out, coll_pos_y_out, coll_dx_out, coll_dy_out, x_out, y_out;
  vel_t coll_vel_x_out, coll_vel_y_out, vel_x_out, vel_y_out;
  acc_t acc_x_out, acc_y_out;
  logic [1:0] collision_count_out;
  logic coll_result_in = 1'b0, coll_was_collision_in = 1'b0;
  pos_t coll_x_new_in = '0, coll_y_new_in = '0, coll_x_int_in = '0, coll_y_int_in = '0;
  vel_t coll_vel_x_new_in = '0, coll_vel_y_new_in = '0;
  acc_t coll_acc_x_in = '0, coll_acc_y_in = '0;

  // scene and collision-unit behaviour tables
  logic [1:0][NV-1:0][7:0] rom_tab [NOBS];
  logic [3:0] nv_tab [NOBS];
  bit   resp [NOBS], hit [NOBS];
  pos_t ix [NOBS], iy [NOBS], nx [NOBS], ny [NOBS];
  vel_t vnx [NOBS], vny [NOBS];
  acc_t ax [NOBS], ay [NOBS];
  int   ul = 3;
  logic [0:0] addr_d1 = '0;

  assign rom_obstacle_in     = rom_tab[addr_d1];
  assign rom_num_vertices_in = nv_tab[addr_d1];

  typedef struct {
    logic [1:0][NV-1:0][7:0] obs; logic [3:0] nv;
    pos_t px, py, dx, dy; vel_t vx, vy;
  } launch_t;
  typedef struct {
    pos_t x, y; vel_t vx, vy; acc_t ax, ay; int cnt; bit to; int lat;
  } res_t;
  launch_t ldq[$];
  res_t    rsq[$];

  int n_tot = 0, n_bad = 0, cyc = 0, t0 = 0;

  collision_scheduler #(.NUM_OBSTACLES(NOBS), .ROM_LATENCY(ROM_LAT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .begin_in(begin_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .dx_in(dx_in), .dy_in(dy_in), .obstacle_addr_out(obstacle_addr_out),
    .rom_obstacle_in(rom_obstacle_in), .rom_num_vertices_in(rom_num_vertices_in),
    .coll_begin_out(coll_begin_out), .coll_obstacle_out(coll_obstacle_out),
    .coll_num_vertices_out(coll_num_vertices_out),
    .coll_pos_x_out(coll_pos_x_out), .coll_pos_y_out(coll_pos_y_out),
    .coll_dx_out(coll_dx_out), .coll_dy_out(coll_dy_out),
    .coll_vel_x_out(coll_vel_x_out), .coll_vel_y_out(coll_vel_y_out),
    .coll_result_in(coll_result_in), .coll_was_collision_in(coll_was_collision_in),
    .coll_x_new_in(coll_x_new_in), .coll_y_new_in(coll_y_new_in),
    .coll_x_int_in(coll_x_int_in), .coll_y_int_in(coll_y_int_in),
    .coll_vel_x_new_in(coll_vel_x_new_in), .coll_vel_y_new_in(coll_vel_y_new_in),
    .coll_acc_x_in(coll_acc_x_in), .coll_acc_y_in(coll_acc_y_in),
    .busy_out(busy_out), .done_out(done_out), .x_out(x_out), .y_out(y_out),
    .vel_x_out(vel_x_out), .vel_y_out(vel_y_out), .acc_x_out(acc_x_out), .acc_y_out(acc_y_out),
    .collision_count_out(collision_count_out), .timeout_out(timeout_out)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  // ROM: data for a new address appears one cycle later, valid by the ROM_LAT-th edge
  initial forever begin @(posedge clk); #1; addr_d1 = obstacle_addr_out; end

  task automatic chk(input string tag, input logic signed [127:0] act, input logic signed [127:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic acc_t sat(input int v);
    if (v > 127)  return 8'sd127;
    if (v < -128) return -8'sd128;
    return acc_t'(v);
  endfunction

  task automatic set_obs(input int i, input int nvv, input bit r, input bit h,
                         input pos_t a, input pos_t b, input pos_t c, input pos_t d,
                         input vel_t e, input vel_t f, input acc_t g, input acc_t k);
    nv_tab[i] = 4'(nvv); resp[i] = r; hit[i] = h;
    ix[i] = a; iy[i] = b; nx[i] = c; ny[i] = d; vnx[i] = e; vny[i] = f; ax[i] = g; ay[i] = k;
    rom_tab[i] = 80'({$urandom(), $urandom(), $urandom()});
  endtask

  // reference model: walks the obstacles and queues expected launches and result
  task automatic sb_push(input pos_t px0, input pos_t py0, input pos_t dx0, input pos_t dy0,
                         input vel_t vx0, input vel_t vy0);
    pos_t px, py, dx, dy; vel_t vx, vy; int sax, say; launch_t l; res_t r;
    px = px0; py = py0; dx = dx0; dy = dy0; vx = vx0; vy = vy0;
    sax = 0; say = 0; r.cnt = 0; r.to = 1'b0; r.lat = 2;
    for (int i = 0; i < NOBS; i++) begin
      r.lat += ROM_LAT;
      if (nv_tab[i] < 4'(MIN_POLY_VERTICES)) begin r.lat += 1; continue; end
      l.obs = rom_tab[i]; l.nv = nv_tab[i];
      l.px = px; l.py = py; l.dx = dx; l.dy = dy; l.vx = vx; l.vy = vy;
      ldq.push_back(l);
      if (!resp[i]) begin r.lat += TMO + 2; r.to = 1'b1; continue; end
      r.lat += ul + 3;
      if (hit[i]) begin
        px = ix[i]; py = iy[i]; dx = nx[i] - ix[i]; dy = ny[i] - iy[i];
        vx = vnx[i]; vy = vny[i]; sax += int'(ax[i]); say += int'(ay[i]); r.cnt++;
      end
    end
    r.x = px + dx; r.y = py + dy; r.vx = vx; r.vy = vy; r.ax = sat(sax); r.ay = sat(say);
    rsq.push_back(r);
  endtask

  // collision unit model
  initial forever begin
    int o;
    @(negedge clk);
    if (rst_n && coll_begin_out) begin
      o = int'(obstacle_addr_out);
      if (resp[o]) begin
        repeat (ul) @(negedge clk);
        coll_was_collision_in = hit[o];
        coll_x_new_in = nx[o]; coll_y_new_in = ny[o]; coll_x_int_in = ix[o]; coll_y_int_in = iy[o];
        coll_vel_x_new_in = vnx[o]; coll_vel_y_new_in = vny[o];
        coll_acc_x_in = ax[o]; coll_acc_y_in = ay[o];
        coll_result_in = 1'b1;
        @(negedge clk);
        coll_result_in = 1'b0;
      end
    end
  end

  // output monitor / scoreboard
  initial forever begin
    launch_t l; res_t r;
    @(negedge clk);
    if (rst_n && coll_begin_out) begin
      chk("launch_expected", ldq.size() > 0, 1);
      if (ldq.size() > 0) begin
        l = ldq.pop_front();
        chk("l_obs", coll_obstacle_out, l.obs);  chk("l_nv", coll_num_vertices_out, l.nv);
        chk("l_px", coll_pos_x_out, l.px);       chk("l_py", coll_pos_y_out, l.py);
        chk("l_dx", coll_dx_out, l.dx);          chk("l_dy", coll_dy_out, l.dy);
        chk("l_vx", coll_vel_x_out, l.vx);       chk("l_vy", coll_vel_y_out, l.vy);
      end
    end
    if (rst_n && done_out) begin
      chk("done_expected", rsq.size() > 0, 1);
      if (rsq.size() > 0) begin
        r = rsq.pop_front();
        chk("x", x_out, r.x);         chk("y", y_out, r.y);
        chk("vx", vel_x_out, r.vx);   chk("vy", vel_y_out, r.vy);
        chk("ax", acc_x_out, r.ax);   chk("ay", acc_y_out, r.ay);
        chk("count", collision_count_out, r.cnt);
        chk("timeout", timeout_out, r.to);
        chk("latency", cyc - t0 + 1, r.lat);
        chk("busy_in_done", busy_out, 1);
      end
    end
  end

  task automatic run_step(input pos_t px, input pos_t py, input pos_t dx, input pos_t dy,
                          input vel_t vx, input vel_t vy, input int hold);
    @(negedge clk);
    pos_x_in = px; pos_y_in = py; dx_in = dx; dy_in = dy; vel_x_in = vx; vel_y_in = vy;
    sb_push(px, py, dx, dy, vx, vy);
    t0 = cyc; begin_in = 1'b1;
    @(negedge clk);
    if (hold > 1) begin
      pos_x_in = pos_x_in + 8'sd50; dx_in = dx_in - 8'sd7;
      repeat (hold - 1) @(negedge clk);
    end
    begin_in = 1'b0;
    for (int i = 0; i < 2000 && rsq.size() != 0; i++) @(negedge clk);
    chk("step_completed", rsq.size(), 0);
    chk("launches_consumed", ldq.size(), 0);
    @(negedge clk);
    chk("idle_after_done", busy_out, 0);
    chk("done_single_pulse", done_out, 0);
  endtask

  initial begin
    int dcount;
    for (int i = 0; i < NOBS; i++) set_obs(i, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_out, 0);  chk("rst_done", done_out, 0);
    chk("rst_x", x_out, 0);        chk("rst_addr", obstacle_addr_out, 0);
    chk("rst_cbeg", coll_begin_out, 0); chk("rst_tmo", timeout_out, 0);
    rst_n = 1'b1;

    // no hits
    run_step(10, 10, 3, -2, 1, 1, 1);
    // obstacle 0 hits, obstacle 1 misses
    set_obs(0, 5, 1, 1, 12, 10, 11, 9, -1, 1, -2, 0);
    run_step(10, 10, 3, -2, 1, 1, 1);
    // both hit: acceleration saturates both ways
    set_obs(0, 5, 1, 1, 12, 10, 11, 9, -1, 1, 100, -100);
    set_obs(1, 4, 1, 1, 5, -3, 20, -30, 7, -8, 100, -100);
    run_step(10, 10, 3, -2, 1, 1, 1);
    // unit silent on obstacle 0
    set_obs(0, 5, 0, 1, 12, 10, 11, 9, -1, 1, 100, 0);
    set_obs(1, 5, 1, 1, 5, -3, 20, -30, 7, -8, 1, 2);
    run_step(-4, 6, 2, 2, 3, -3, 1);
    // obstacle 1 is not a polygon
    set_obs(0, 5, 1, 1, 12, 10, 11, 9, -1, 1, -2, 0);
    set_obs(1, 2, 1, 1, 5, -3, 20, -30, 7, -8, 50, 50);
    run_step(10, 10, 3, -2, 1, 1, 1);
    // minimum polygon, position sum wraps
    set_obs(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_obs(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_step(120, -120, 20, -20, -5, 5, 1);
    // random scenes
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NOBS; i++)
        set_obs(i, int'($urandom_range(2, 5)), 1, 1'($urandom_range(0, 1)),
                pos_t'($urandom), pos_t'($urandom), pos_t'($urandom), pos_t'($urandom),
                vel_t'($urandom), vel_t'($urandom), acc_t'($urandom), acc_t'($urandom));
      run_step(pos_t'($urandom), pos_t'($urandom), pos_t'($urandom), pos_t'($urandom),
               vel_t'($urandom), vel_t'($urandom), 1);
    end

    // reset while waiting on the unit
    set_obs(0, 5, 1, 1, 12, 10, 11, 9, -1, 1, -2, 0);
    set_obs(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_step(10, 10, 3, -2, 1, 1, 1);
    ul = 20;
    @(negedge clk);
    pos_x_in = 33; pos_y_in = 44;
    sb_push(33, 44, 3, -2, 1, 1);
    begin_in = 1'b1;
    @(negedge clk);
    begin_in = 1'b0;
    for (int i = 0; i < 50 && !coll_begin_out; i++) @(negedge clk);
    chk("launch_seen", coll_begin_out, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_out, 0);   chk("arst_x", x_out, 0);      chk("arst_y", y_out, 0);
    chk("arst_vx", vel_x_out, 0);    chk("arst_ax", acc_x_out, 0); chk("arst_cnt", collision_count_out, 0);
    chk("arst_cpos", coll_pos_x_out, 0); chk("arst_done", done_out, 0);
    ldq.delete(); rsq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_out) dcount++;
    end
    chk("no_done_after_rst", dcount, 0);
    chk("idle_after_rst", busy_out, 0);
    // begin held high while busy: only the first sample counts
    ul = 3;
    run_step(10, 10, 3, -2, 1, 1, 5);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

endmodule
